// File: rtl/amdc_adc_emu_pkg.sv
// Shared types and defaults for the AD4011 dual-channel responder model.
//   state_e          : controller states (IDLE / CONV / SHIFT)
//   DATA_WIDTH_DEF   : bits per frame per channel
//   CONV_CYCLES_DEF  : clk cycles from detected cnv rise to MSB presentation
//   CNT_W_DEF        : conversion counter width (2**CNT_W_DEF > CONV_CYCLES_DEF)
//   CLK_PERIOD_PS    : clk period, 200 MHz
package amdc_adc_emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF  = 18;
  localparam int CONV_CYCLES_DEF = 60;
  localparam int CNT_W_DEF       = 8;
  localparam int CLK_PERIOD_PS   = 5000;

endpackage

// File: rtl/amdc_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin, with edge pulses taken
// from the last two stages so they are metastability-safe.
//   clk, rst_n : clock, async active-low reset (all flops clear to 0)
//   async_i    : asynchronous input pin
//   rise_o     : one-cycle pulse, s2 & ~s3
//   fall_o     : one-cycle pulse, ~s2 & s3
// An edge on async_i is acted on by downstream logic at the 3rd clk edge.
module amdc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/amdc_adc_emulator.sv
// Responder-side model of a dual-channel AD4011 18-bit SPI ADC.
// A cnv rise snapshots data_x_in/data_y_in, a conversion delay is emulated,
// then both words are shifted out MSB-first on each sclk falling edge.
//   clk, rst_n          : clock, async active-low reset
//   cnv, sclk           : asynchronous master lines (sclk idles low)
//   data_x_in/data_y_in : words returned on the next frame
//   clr_err             : clears overrun / early_sclk (a coincident set wins)
//   miso_x, miso_y      : registered serial data, 0 outside SHIFT
//   busy                : registered, high in CONV or SHIFT
//   frame_done          : one-cycle pulse after the last bit's sclk fall
//   overrun             : sticky, cnv rose while busy
//   early_sclk          : sticky, sclk fell during CONV
//
// state | meaning
// IDLE  | waiting for cnv rise, miso held at 0, sclk ignored
// CONV  | emulated conversion time, miso held at 0
// SHIFT | presenting shx/shy MSBs, shifting on each sclk fall
module amdc_adc_emulator
  import amdc_adc_emu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CONV_CYCLES = CONV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnv,
  input  logic                  sclk,
  input  logic [DATA_WIDTH-1:0] data_x_in,
  input  logic [DATA_WIDTH-1:0] data_y_in,
  input  logic                  clr_err,
  output logic                  miso_x,
  output logic                  miso_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  early_sclk
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  logic cnv_rise, cnv_fall_unused;
  logic sclk_rise_unused, sclk_fall;

  amdc_sync_edge u_sync_cnv (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(cnv),
    .rise_o (cnv_rise),
    .fall_o (cnv_fall_unused)
  );

  amdc_sync_edge u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(sclk),
    .rise_o (sclk_rise_unused),
    .fall_o (sclk_fall)
  );

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shx_q, shx_d, shy_q, shy_d;
  logic [CNT_W-1:0]      conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  miso_x_q, miso_x_d, miso_y_q, miso_y_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d, early_q, early_d;
  logic                  ovr_set, early_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shx_q        <= '0;
      shy_q        <= '0;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      miso_x_q     <= 1'b0;
      miso_y_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      early_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shx_q        <= shx_d;
      shy_q        <= shy_d;
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_x_q     <= miso_x_d;
      miso_y_q     <= miso_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      early_q      <= early_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shx_d        = shx_q;
    shy_d        = shy_q;
    conv_cnt_d   = conv_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    ovr_set      = 1'b0;
    early_set    = 1'b0;

    // cnv rise beats everything, including a coincident sclk fall.
    if (cnv_rise) begin
      ovr_set    = (state_q != ST_IDLE);
      shx_d      = data_x_in;
      shy_d      = data_y_in;
      conv_cnt_d = '0;
      bit_cnt_d  = '0;
      state_d    = ST_CONV;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_CONV: begin
          early_set  = sclk_fall;
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
          if (conv_cnt_q == CONV_LAST) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_fall) begin
            shx_d     = {shx_q[DATA_WIDTH-2:0], 1'b0};
            shy_d     = {shy_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are computed from next state so the MSB is on the pin in the
    // very first SHIFT cycle and miso drops the same edge the frame ends.
    miso_x_d  = (state_d == ST_SHIFT) ? shx_d[DATA_WIDTH-1] : 1'b0;
    miso_y_d  = (state_d == ST_SHIFT) ? shy_d[DATA_WIDTH-1] : 1'b0;
    busy_d    = (state_d != ST_IDLE);
    overrun_d = ovr_set | (overrun_q & ~clr_err);
    early_d   = early_set | (early_q & ~clr_err);
  end

  assign miso_x     = miso_x_q;
  assign miso_y     = miso_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign early_sclk = early_q;

endmodule
